// File: rtl/mlsu_pkg.sv
// Types and constants for the MLSU fragmenter / transaction issuer pair.
// Pure type definitions, no logic.
// No flow control of its own.
package mlsu_pkg;

   localparam int unsigned REQ_ID_W     = 4;
   localparam int unsigned SEG_CNT_W    = 8;
   localparam int unsigned TXN_CNT_W    = 16;
   localparam int unsigned LEN_W        = 14;    // holds 1..8192 nibbles
   localparam int unsigned PAGE_OFF_W   = 13;
   localparam int unsigned PAGE_NIBBLES = 8192;  // one memory page, in nibbles

   // request-global part of a descriptor, as produced by the fragmenter
   typedef struct packed {
      logic [REQ_ID_W-1:0]  req_id;
      logic                 is_load;
      logic [SEG_CNT_W-1:0] rmn_seg;
      logic [SEG_CNT_W-1:0] rmn_grp;
   } glb_meta_t;

   // segment-level part: nibble base address, txn index within segment, tail length
   typedef struct packed {
      riva_pkg::elen_t      seg_base_addr;
      logic [TXN_CNT_W-1:0] txn_num;
      logic [TXN_CNT_W-1:0] txn_cnt;
      logic [LEN_W-1:0]     lt_n;
   } seglv_meta_t;

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/riva_pkg.sv
// Core-wide scalar types shared by the vector load/store path.
// Pure type definitions, no logic.
// No flow control of its own.
package riva_pkg;

   localparam int unsigned ELEN = 32;

   typedef logic [ELEN-1:0] elen_t;

endpackage

// File: rtl/mlsu_txn_issuer_txn_addr_gen.sv
// Turns one segment-level descriptor into a byte address and a nibble length.
// Purely combinational, zero latency.
// No flow control; the caller registers the result.
module txn_addr_gen
   import mlsu_pkg::*;
#(
   parameter type meta_seglv_t = seglv_meta_t
) (
   input  meta_seglv_t       seglv,
   output riva_pkg::elen_t   addr,
   output logic [LEN_W-1:0]  len
);

   localparam int unsigned AW = $bits(riva_pkg::elen_t);

   logic [PAGE_OFF_W-1:0] page_off;
   riva_pkg::elen_t       page_base;
   riva_pkg::elen_t       cnt_off;
   riva_pkg::elen_t       nib_addr;

   // first txn starts at the raw base, later ones at page boundaries; address wraps silently
   always_comb begin
      page_off  = seglv.seg_base_addr[PAGE_OFF_W-1:0];
      page_base = {seglv.seg_base_addr[AW-1:PAGE_OFF_W], {PAGE_OFF_W{1'b0}}};
      cnt_off   = AW'(seglv.txn_cnt) << PAGE_OFF_W;
      nib_addr  = (seglv.txn_cnt == '0) ? seglv.seg_base_addr : (page_base + cnt_off);
      addr      = nib_addr >> 1;
      if (seglv.txn_num == '0) begin
         len = seglv.lt_n - LEN_W'(page_off);
      end else if (seglv.txn_cnt == '0) begin
         len = LEN_W'(PAGE_NIBBLES) - LEN_W'(page_off);
      end else if (seglv.txn_cnt < seglv.txn_num) begin
         len = LEN_W'(PAGE_NIBBLES);
      end else begin
         len = seglv.lt_n;
      end
   end

endmodule

// File: rtl/mlsu_txn_issuer.sv
// Issues memory transactions from fragmenter descriptors, tracks responses, signals request completion.
// Descriptor accepted in cycle N appears on txn_* in cycle N+1; done pulses one cycle after full drain.
// txn_* holds under txn_ready_i low; descriptors stall on a busy output or MaxOutstanding in flight.
module mlsu_txn_issuer
   import mlsu_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 8,
   parameter type meta_glb_t   = glb_meta_t,
   parameter type meta_seglv_t = seglv_meta_t
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                meta_valid_i,
   output logic                meta_ready_o,
   input  meta_glb_t           meta_glb_i,
   input  meta_seglv_t         meta_seglv_i,
   output logic                txn_valid_o,
   input  logic                txn_ready_i,
   output riva_pkg::elen_t     txn_addr_o,
   output logic [LEN_W-1:0]    txn_len_o,
   output logic                txn_is_load_o,
   output logic [REQ_ID_W-1:0] txn_id_o,
   input  logic                rsp_valid_i,
   output logic                rsp_ready_o,
   output logic                done_valid_o,
   output logic [REQ_ID_W-1:0] done_id_o,
   output logic                err_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   state_e                state_q, state_d;
   logic [CntW-1:0]       outstanding_q;
   logic [CntW:0]         pending;
   logic                  credit_ok;
   logic                  txn_hs;
   logic                  meta_fire;
   logic                  is_final;
   riva_pkg::elen_t       gen_addr;
   logic [LEN_W-1:0]      gen_len;

   txn_addr_gen #(
      .meta_seglv_t (meta_seglv_t)
   ) u_addr_gen (
      .seglv (meta_seglv_i),
      .addr  (gen_addr),
      .len   (gen_len)
   );

   // a txn sitting in the output register already claims a credit
   assign pending     = {1'b0, outstanding_q} + {{CntW{1'b0}}, txn_valid_o};
   assign credit_ok   = pending < (CntW+1)'(MaxOutstanding);
   assign txn_hs      = txn_valid_o && txn_ready_i;
   assign meta_fire   = meta_valid_i && meta_ready_o;
   assign is_final    = (meta_glb_i.rmn_grp == '0) && (meta_glb_i.rmn_seg == '0) &&
                        (meta_seglv_i.txn_cnt == meta_seglv_i.txn_num);
   assign rsp_ready_o = 1'b1;

   // next state, descriptor acceptance and done pulse
   always_comb begin
      state_d      = state_q;
      meta_ready_o = 1'b0;
      done_valid_o = 1'b0;
      unique case (state_q)
         S_ISSUE: begin
            meta_ready_o = (!txn_valid_o || txn_ready_i) && credit_ok;
            if (meta_valid_i && meta_ready_o && is_final) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!txn_valid_o && (outstanding_q == '0)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_valid_o = 1'b1;
            state_d      = S_ISSUE;
         end
         default: state_d = S_ISSUE;
      endcase
   end

   // state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_ISSUE;
      end else begin
         state_q <= state_d;
      end
   end

   // output register: load on accept, hold until taken
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         txn_valid_o   <= 1'b0;
         txn_addr_o    <= '0;
         txn_len_o     <= '0;
         txn_is_load_o <= 1'b0;
         txn_id_o      <= '0;
      end else if (meta_fire) begin
         txn_valid_o   <= 1'b1;
         txn_addr_o    <= gen_addr;
         txn_len_o     <= gen_len;
         txn_is_load_o <= meta_glb_i.is_load;
         txn_id_o      <= meta_glb_i.req_id;
      end else if (txn_hs) begin
         txn_valid_o   <= 1'b0;
      end
   end

   // request id reported by the done pulse, captured with the final descriptor
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_id_o <= '0;
      end else if (meta_fire && is_final) begin
         done_id_o <= meta_glb_i.req_id;
      end
   end

   // in-flight counter; a response with nothing in flight is flagged, never underflows
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
         err_o         <= 1'b0;
      end else if (txn_hs && !rsp_valid_i) begin
         outstanding_q <= outstanding_q + CntW'(1);
      end else if (!txn_hs && rsp_valid_i) begin
         if (outstanding_q != '0) begin
            outstanding_q <= outstanding_q - CntW'(1);
         end else begin
            err_o <= 1'b1;
         end
      end
   end

endmodule
